// File: rtl/spram_pkg.sv
// Shared types and widths for the 16-bit x 64K SPRAM arbiter.
// Latency: none (types and constants only).
// Backpressure: none.
package spram_pkg;

    localparam int SPRAM_AW = 17;
    localparam int SPRAM_DW = 16;
    localparam int SPRAM_MW = 4;

    typedef struct packed {
        logic                we;
        logic [SPRAM_AW-1:0] ai;
        logic [SPRAM_DW-1:0] vi;
        logic [SPRAM_MW-1:0] bmsk;
    } spram_req_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_st_e;

endpackage

// File: rtl/spram16_arb_rr_pick.sv
// Round-robin priority picker: first unmasked request at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; losers simply see no grant this cycle.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          hit
);

    always_comb begin : pick
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!hit && req[j] && !mask[j]) begin
                hit    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/spram16_arb.sv
// Round-robin arbiter sharing one SPRAM port among NREQ requesters; SPRAM_ARB_LOCK_EN adds bus locking.
// Latency: grant and memory drive combinational; read data returns with rvld exactly one cycle later.
// Backpressure: a requester without gnt must hold its request; lock starves others for at most MAX_LOCK cycles.
module spram16_arb
    import spram_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int MAX_LOCK = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ-1:0]                lock,
    input  logic [NREQ-1:0]                we,
    input  logic [NREQ-1:0][SPRAM_AW-1:0]  ai,
    input  logic [NREQ-1:0][SPRAM_DW-1:0]  vi,
    input  logic [NREQ-1:0][SPRAM_MW-1:0]  bmsk,
    output logic [NREQ-1:0]                gnt,
    output logic [NREQ-1:0]                rvld,
    output logic [SPRAM_DW-1:0]            vo,
    output logic                           m_we,
    output logic [SPRAM_AW-1:0]            m_ai,
    output logic [SPRAM_DW-1:0]            m_vi,
    output logic [SPRAM_MW-1:0]            m_bmsk,
    input  logic [SPRAM_DW-1:0]            m_vo
);

    localparam int PW = $clog2(NREQ);

    spram_req_t [NREQ-1:0] rq;
    spram_req_t            sel;
    logic [NREQ-1:0]       pick_gnt;
    logic [NREQ-1:0]       pick_mask;
    logic [PW-1:0]         pick_idx;
    logic                  pick_hit;
    logic                  granted;
    logic                  hold;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         nxt_ptr;
    logic                  rd_pend;
    logic [PW-1:0]         rd_tag;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rq[i] = '{we: we[i], ai: ai[i], vi: vi[i], bmsk: bmsk[i]};
        end
    end

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req  (req),
        .mask (pick_mask),
        .ptr  (rr_ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .hit  (pick_hit)
    );

    // Held at idle during reset so the memory never sees a stray write.
    assign granted = pick_hit & ~rst;
    assign gnt     = granted ? pick_gnt : '0;
    assign sel     = granted ? rq[pick_idx] : '0;
    assign m_we    = sel.we;
    assign m_ai    = sel.ai;
    assign m_vi    = sel.vi;
    assign m_bmsk  = sel.bmsk;
    assign nxt_ptr = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            rd_pend <= 1'b0;
            rd_tag  <= '0;
        end else begin
            rd_pend <= granted & ~sel.we;
            if (granted && !sel.we) begin
                rd_tag <= pick_idx;
            end
            if (granted && !hold) begin
                rr_ptr <= nxt_ptr;
            end
        end
    end

    always_comb begin
        rvld = '0;
        if (rd_pend) begin
            rvld[rd_tag] = 1'b1;
        end
    end

    assign vo = m_vo;

`ifdef SPRAM_ARB_LOCK_EN
    localparam int             CW   = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0]  CMAX = CW'(MAX_LOCK);

    arb_st_e         st, st_n;
    logic [PW-1:0]   own, own_n;
    logic [CW-1:0]   lock_cnt, cnt_n;
    logic            bar, bar_n;
    logic [NREQ-1:0] own_oh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ARB_IDLE;
            own      <= '0;
            lock_cnt <= '0;
            bar      <= 1'b0;
        end else begin
            st       <= st_n;
            own      <= own_n;
            lock_cnt <= cnt_n;
            bar      <= bar_n;
        end
    end

    // bar: the owner just hit the lock limit and sits out one turn if anyone else wants the bus.
    always_comb begin
        st_n      = st;
        own_n     = own;
        cnt_n     = lock_cnt;
        bar_n     = 1'b0;
        hold      = 1'b0;
        pick_mask = '0;
        own_oh    = '0;
        own_oh[own] = 1'b1;
        if (st == ARB_OWN) begin
            pick_mask = ~own_oh;
        end else if (bar && |(req & ~own_oh)) begin
            pick_mask = own_oh;
        end
        case (st)
            ARB_IDLE: begin
                if (granted && lock[pick_idx]) begin
                    own_n = pick_idx;
                    cnt_n = CW'(1);
                    if (cnt_n == CMAX) begin
                        bar_n = 1'b1;
                    end else begin
                        st_n = ARB_OWN;
                        hold = 1'b1;
                    end
                end
            end
            ARB_OWN: begin
                if (granted) begin
                    cnt_n = (lock_cnt == CMAX) ? CMAX : lock_cnt + 1'b1;
                end
                if (!lock[own] || !req[own] || cnt_n == CMAX) begin
                    st_n  = ARB_IDLE;
                    bar_n = granted && (cnt_n == CMAX);
                    cnt_n = '0;
                end else begin
                    hold = granted;
                end
            end
            default: begin
                st_n = ARB_IDLE;
            end
        endcase
    end
`else
    logic            unused_lock;
    localparam int   unused_max_lock = MAX_LOCK;

    assign pick_mask   = '0;
    assign hold        = 1'b0;
    assign unused_lock = ^lock;
`endif

endmodule

// File: tb/tb_spram16_arb.sv
// Randomised and directed checks of spram16_arb against a queue-free behavioural model and an SPRAM model.
// Model tracks pointer, pending read and shadow memory; directed cases pin literal values.
module tb_spram16_arb;

    localparam int N  = 3;
    localparam int ML = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        req, lock, we;
    logic [N-1:0][16:0]  ai;
    logic [N-1:0][15:0]  vi;
    logic [N-1:0][3:0]   bmsk;
    logic [N-1:0]        gnt, rvld;
    logic [15:0]         vo, m_vi, m_vo;
    logic                m_we;
    logic [16:0]         m_ai;
    logic [3:0]          m_bmsk;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem    [65536];
    logic [15:0] shadow [65536];

    always #5 clk = ~clk;

    spram16_arb #(
        .NREQ     (N),
        .MAX_LOCK (ML)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .we     (we),
        .ai     (ai),
        .vi     (vi),
        .bmsk   (bmsk),
        .gnt    (gnt),
        .rvld   (rvld),
        .vo     (vo),
        .m_we   (m_we),
        .m_ai   (m_ai),
        .m_vi   (m_vi),
        .m_bmsk (m_bmsk),
        .m_vo   (m_vo)
    );

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [3:0] msk);
        logic [15:0] r;
        r = old;
        for (int n = 0; n < 4; n++) begin
            if (msk[n]) r[n*4 +: 4] = nw[n*4 +: 4];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // SPRAM macro: one-cycle registered read, output holds across writes.
    always @(posedge clk) begin
        if (m_we) mem[m_ai[16:1]] <= merge(mem[m_ai[16:1]], m_vi, m_bmsk);
        else      m_vo <= mem[m_ai[16:1]];
    end

    // Behavioural model and per-cycle compare.
    int          ptr = 0, rpend = 0, rtag = 0, own = -1, cnt = 0, bar = -1;
    logic [15:0] rdat = '0;

    always @(negedge clk) begin : model
        logic [N-1:0] elig;
        int eg, j, w, nbar;
        bit retained;
        if (rst) begin
            ptr = 0; rpend = 0; own = -1; cnt = 0; bar = -1;
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_rvld", 32'(rvld), 0);
            chk("rst_mwe", 32'(m_we), 0);
        end else begin
            chk("rvld", 32'(rvld), rpend ? 32'(1 << rtag) : 0);
            if (rpend != 0) chk("vo", 32'(vo), 32'(rdat));
            elig = req;
`ifdef SPRAM_ARB_LOCK_EN
            if (own >= 0) elig = req & N'(1 << own);
            else if (bar >= 0 && (req & ~N'(1 << bar)) != 0) elig = req & ~N'(1 << bar);
`endif
            eg = -1;
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (eg < 0 && elig[j]) eg = j;
            end
            chk("gnt", 32'(gnt), eg >= 0 ? 32'(1 << eg) : 0);
            chk("m_we", 32'(m_we), eg >= 0 ? 32'(we[eg]) : 0);
            chk("m_ai", 32'(m_ai), eg >= 0 ? 32'(ai[eg]) : 0);
            chk("m_vi", 32'(m_vi), eg >= 0 ? 32'(vi[eg]) : 0);
            chk("m_bmsk", 32'(m_bmsk), eg >= 0 ? 32'(bmsk[eg]) : 0);
            rpend = 0;
            if (eg >= 0) begin
                w = int'(ai[eg][16:1]);
                if (we[eg]) shadow[w] = merge(shadow[w], vi[eg], bmsk[eg]);
                else begin rpend = 1; rtag = eg; rdat = shadow[w]; end
            end
            retained = 1'b0;
            nbar = -1;
`ifdef SPRAM_ARB_LOCK_EN
            if (own >= 0) begin
                if (eg == own) cnt = (cnt < ML) ? cnt + 1 : ML;
                if (!lock[own] || !req[own] || cnt >= ML) begin
                    if (eg == own && cnt >= ML) nbar = own;
                    own = -1; cnt = 0;
                end else retained = (eg == own);
            end else if (eg >= 0 && lock[eg]) begin
                cnt = 1;
                if (ML > 1) begin own = eg; retained = 1'b1; end
                else nbar = eg;
            end
`endif
            bar = nbar;
            if (eg >= 0 && !retained) ptr = (eg + 1) % N;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0; lock = '0; we = '0;
    endtask

    initial begin
        logic [N-1:0] seq_lock [5];
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i) ^ 16'hA5A5;
            shadow[i] = 16'(i) ^ 16'hA5A5;
        end
        req = '0; lock = '0; we = '0; ai = '0; vi = '0; bmsk = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Round-robin among r0/r1, all reads.
        req = 3'b011; ai[0] = 17'h00100; ai[1] = 17'h00102;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(gnt), (c % 2 == 1) ? 32'h2 : 32'h1);
            if (c > 0) begin
                chk("rr_rvld", 32'(rvld), (c % 2 == 1) ? 32'h1 : 32'h2);
                chk("rr_vo", 32'(vo), (c % 2 == 1) ? 32'hA525 : 32'hA524);
            end
            tick();
        end

        // Write then read-back.
        idle(); req = 3'b010; we = 3'b010; ai[1] = 17'h1A002; vi[1] = 16'hBEEF; bmsk[1] = 4'hF;
        tick();
        idle(); req = 3'b001; ai[0] = 17'h1A002;
        @(negedge clk); chk("wr_rd_gnt", 32'(gnt), 32'h1);
        tick(); idle();
        @(negedge clk);
        chk("wr_rd_rvld", 32'(rvld), 32'h1);
        chk("wr_rd_vo", 32'(vo), 32'hBEEF);

        // Nibble mask.
        tick(); req = 3'b100; we = 3'b100; ai[2] = 17'h00200; vi[2] = 16'h1234; bmsk[2] = 4'hF;
        tick(); vi[2] = 16'hABCD; bmsk[2] = 4'b0001;
        tick(); we = '0;
        tick(); idle();
        @(negedge clk);
        chk("nib_rvld", 32'(rvld), 32'h4);
        chk("nib_vo", 32'(vo), 32'h123D);

        // Reset mid-read.
        tick(); req = 3'b001; ai[0] = 17'h00100;
        tick(); rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rvld", 32'(rvld), 0);
        chk("rst_mid_gnt", 32'(gnt), 0);
        chk("rst_mid_ptr", 32'(dut.rr_ptr), 0);
        chk("rst_mid_mwe", 32'(m_we), 0);
        tick(); rst = 1'b0; idle();
        @(negedge clk);
        chk("rst_after_rvld", 32'(rvld), 0);

        // Lock: r0 holds req+lock while r1 requests.
`ifdef SPRAM_ARB_LOCK_EN
        seq_lock = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001};
`else
        seq_lock = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
`endif
        tick(); req = 3'b011; lock = 3'b001; ai[0] = 17'h00040; ai[1] = 17'h00042;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("lock_gnt", 32'(gnt), 32'(seq_lock[c]));
            tick();
        end
        idle();
        tick();

        // Random traffic over a small address window so reads hit earlier writes.
        for (int c = 0; c < 3000; c++) begin
            req  = N'($urandom_range(0, 7));
            we   = N'($urandom);
            lock = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++) begin
                ai[i]   = 17'(($urandom_range(0, 15) + 16) * 2 + $urandom_range(0, 1));
                vi[i]   = 16'($urandom);
                bmsk[i] = 4'($urandom);
            end
            rst = (c == 1500);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spram16_arb.md
Name: spram16_arb

Overview:
- Round-robin arbiter that shares one 16-bit x 64K single-port SPRAM macro between NREQ requesters, e.g. eForth core fetch/data, UART loader and debug port.
- Sits between the requesters and the memory-bus side of the SPRAM bank module. It drives that module's we/ai/vi/bmsk and consumes its vo.
- Issues one access per cycle, tracks the one-cycle read latency, and steers returned data to the correct requester.
- Supports optional bus locking for read-modify-write sequences.

Parameters:
- NREQ, 2, number of requesters (2..4).
- MAX_LOCK, 15, maximum consecutive locked cycles before a forced release (only used with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester access request.
- lock  in  NREQ  per-requester hold-bus request.
- we  in  NREQ  per-requester write enable (1 = write, 0 = read).
- ai  in  NREQx17  per-requester byte address; bits [16:1] select the word.
- vi  in  NREQx16  per-requester write data.
- bmsk  in  NREQx4  per-requester nibble write mask.
- gnt  out  NREQ  one-hot; access accepted this cycle.
- rvld  out  NREQ  one-hot; read data valid on vo this cycle.
- vo  out  16  read data, shared by all requesters.
- m_we  out  1  SPRAM write enable.
- m_ai  out  17  SPRAM address.
- m_vi  out  16  SPRAM write data.
- m_bmsk  out  4  SPRAM mask.
- m_vo  in  16  SPRAM read data, valid one cycle after the read is issued.

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset rst is asynchronous and active-high.
  - Reset values: gnt=0, rvld=0, rr_ptr=0, lock state = IDLE, lock_cnt=0, rd_tag=0, rd_pend=0.
  - Outputs while no grant: m_we=0, m_ai=0, m_vi=0, m_bmsk=0.
- Grant (combinational, same cycle):
  - gnt[i]=1 for the first requester with req[i]=1, searching from rr_ptr upward with modulo-NREQ wrap.
  - At most one gnt bit is set. gnt=0 when req=0.
- Memory drive:
  - m_we/m_ai/m_vi/m_bmsk are muxed combinationally from the granted requester.
  - m_we is forced to 0 when there is no grant, so the memory sees an idle read and its output bank select does not change on writes.
- Pointer update:
  - On a grant to i with no lock retained, rr_ptr <= (i+1) mod NREQ on the next edge.
  - If the grant is retained under lock, rr_ptr is unchanged.
- Read return:
  - A granted read (we[i]=0) sets rd_pend<=1 and rd_tag<=i.
  - Next cycle: rvld[rd_tag]=1 and vo=m_vo. rvld is registered, so latency is exactly 1 cycle.
  - Back-to-back reads from different requesters each get their own rvld on consecutive cycles.
- Writes complete in the grant cycle; no rvld is produced for them.
- Simultaneous events:
  - A read return and a new grant in the same cycle are independent.
  - A requester may hold req continuously; it receives one grant per arbitration turn.
- Reset mid-operation: any pending rvld is dropped, and the read data is discarded.
- Lock state machine (only active with SPRAM_ARB_LOCK_EN):
  - IDLE -> OWN(i) when gnt[i] and lock[i] are both 1. lock_cnt is set to 1.
  - While in OWN(i):
    - Only requester i is eligible; other req bits are ignored.
    - lock_cnt increments on every cycle with gnt[i].
  - OWN -> IDLE when any of these occurs:
    - lock[i]=0;
    - req[i]=0 for a cycle;
    - lock_cnt reaches MAX_LOCK.
  - On a MAX_LOCK release, rr_ptr <= i+1, and requester i is masked out for one cycle if any other req bit is set.
  - lock_cnt saturates at MAX_LOCK. Its width is clog2(MAX_LOCK+1).

Optional Feature:
- Macro: SPRAM_ARB_LOCK_EN.
- Defined: lock ports are honoured, and the OWN state, lock_cnt and forced release are compiled in.
- Undefined: the lock port is still present but ignored. The arbiter is pure round-robin with no lock state or counter.

Decomposition:
- Package spram_pkg holds:
  - typedef spram_req_t: struct {we, ai[16:0], vi[15:0], bmsk[3:0]};
  - constants SPRAM_AW=17, SPRAM_DW=16, SPRAM_MW=4;
  - enum arb_st_e {ARB_IDLE, ARB_OWN}.
- One sub-module, rr_pick: a combinational round-robin priority picker taking req, mask and ptr, and returning one-hot gnt plus the granted index.

Test Plan:
- Reset: assert rst mid-read (req0 read at 0x00100). Required: rvld=0 next cycle, gnt=0, rr_ptr=0, m_we=0.
- Round-robin, NREQ=2: req=2'b11 held, all reads. Required: gnt alternates 01,10,01,10; rvld follows one cycle later with vo equal to the preloaded words at each address.
- Write then read-back: r1 writes 0xBEEF to 0x1A002 with bmsk=4'hF; next cycle r0 reads 0x1A002. Required: rvld[0]=1 and vo=0xBEEF one cycle after r0's grant.
- Nibble mask: word is 0x1234; write 0xABCD with bmsk=4'b0001, then read. Required: read returns 0x123D.
- Lock (macro on, MAX_LOCK=3): r0 holds req+lock while r1 requests. Required: gnt[0] for 3 cycles, then gnt[1] for one cycle, then r0 again.
- Lock (macro off): same stimulus as the lock test. Required: strict alternation 01,10.
